pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Sequencing controller for the 64-bit pipeline program counter and the IF/ID and ID/EX pipeline registers.
- Computes the next PC each cycle: sequential +4, a taken-branch target, or the reset vector.
- Drives the PC write enable and the pipeline write, flush and hold controls.
- Resolves, in fixed priority, boot after reset, data-memory wait, branch redirect and load-use hazards.

Parameters:
- XLEN, 64, PC and target width.
- RESET_VECTOR, 64'd0, PC value forced on the first cycle after reset release.
- STALL_CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_current  in  XLEN  current PC register output.
- id_rs1  in  5  source register 1 of the instruction in ID.
- id_rs2  in  5  source register 2 of the instruction in ID.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- ex_branch_target  in  XLEN  resolved target.
- mem_busy  in  1  data memory not ready; the pipeline must freeze.
- pc_next  out  XLEN  value to load into the PC.
- pc_write  out  1  PC write enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID register clear.
- id_ex_flush  out  1  insert a bubble into ID/EX.
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- misalign_err  out  1  one-cycle pulse: redirect target has bits [1:0] != 0.
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with pc_write=0.
- seq_state  out  2  current FSM state, for debug.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). All registers clear on reset assertion.
- Registered state:
  - FSM with states BOOT, RUN, MEM_WAIT.
  - pending_valid (1 bit) and pending_target (XLEN).
  - stall_cycles.
- Reset values: state=BOOT, pending_valid=0, pending_target=0, stall_cycles=0.
- While reset is high the outputs are: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, pipe_hold=0, misalign_err=0, pc_next=RESET_VECTOR.
- All control outputs are combinational (Mealy) from the state and the current inputs, so hazards act in the same cycle. Latency to the PC is one edge.
- BOOT (exactly one cycle after reset release):
  - pc_next=RESET_VECTOR, pc_write=1, if_id_flush=1, id_ex_flush=1.
  - Next state is RUN. All other inputs are ignored.
- RUN, evaluated in priority order:
  1. mem_busy=1: pc_write=0, if_id_write=0, pipe_hold=1, no flushes, next state MEM_WAIT. If ex_branch_taken=1 in this cycle, set pending_valid=1 and pending_target=ex_branch_target.
  2. ex_branch_taken=1: pc_next=ex_branch_target, pc_write=1, if_id_flush=1, id_ex_flush=1. This overrides load-use.
  3. Load-use: ex_mem_read=1 and ex_rd!=0 and (ex_rd==id_rs1 or ex_rd==id_rs2). Outputs: pc_write=0, if_id_write=0, id_ex_flush=1. This lasts one cycle only; the hazard clears naturally when the load advances.
  4. Otherwise: pc_next=pc_current+4 (modulo 2^XLEN, wraps), pc_write=1, if_id_write=1.
- MEM_WAIT:
  - While mem_busy=1:
    - Full freeze, as in RUN case 1.
    - If ex_branch_taken=1 and pending_valid=0, capture the target. The first capture wins; the held EX instruction re-asserts the same branch every cycle.
  - Cycle with mem_busy=0:
    - If pending_valid: act as a branch redirect using pending_target, then clear pending_valid.
    - Otherwise: evaluate RUN cases 2 to 4.
    - Next state is RUN.
- misalign_err pulses in any cycle that redirects to a target with [1:0]!=0. The redirect still occurs, unmodified.
- stall_cycles increments on every non-reset edge where pc_write=0, including BOOT-excluded freeze cycles. It saturates at all-ones.
- Reset mid-MEM_WAIT discards the pending target; the sequence restarts at BOOT.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state typedef (BOOT=2'd0, RUN=2'd1, MEM_WAIT=2'd2);
  - the PC_STEP=4 constant;
  - the register-index width constant, 5.
- One sub-module, hazard_detect: purely combinational load-use compare, reusable by the forwarding unit.
- The remaining logic stays flat.

Test Plan:
- Reset release: reset high 3 cycles then low, pc_current=0x40 → first cycle pc_next=0, pc_write=1, both flushes=1; next cycle pc_next=0x44, seq_state=RUN.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 for 1 cycle → pc_write=0, if_id_write=0, id_ex_flush=1, stall_cycles +1; with ex_rd=0 → no stall.
- Branch vs load-use together: target 0x1000 plus a matching load-use → pc_next=0x1000, pc_write=1, both flushes, no stall.
- Branch during memory wait: mem_busy high 4 cycles, ex_branch_taken=1 with target 0x2000 held throughout, target changed to 0x3000 in cycle 3 → pipe_hold=1 for 4 cycles, then pc_next=0x2000 with flushes, stall_cycles +4.
- Wrap and misalign: pc_current=0xFFFF_FFFF_FFFF_FFFC → pc_next=0. Branch to 0x1002 → misalign_err one cycle, pc_next=0x1002.
- Reset asserted mid-MEM_WAIT with a pending target → after release BOOT redirects to RESET_VECTOR and the pending target is never used; stall counter saturation checked with STALL_CNT_W=4.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
//==============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared types and constants for the pipeline sequencing logic.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int PC_STEP   = 4;
    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
//==============================================================================
// Module   : hazard_detect
// Brief    : Combinational load-use hazard compare between EX and ID stages.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    output logic                 load_use
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
//==============================================================================
// Module   : pc_sequencer
// Brief    : Next-PC selection and IF/ID, ID/EX pipeline control sequencer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int               XLEN         = 64,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int               STALL_CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [XLEN-1:0]        pc_current,
    input  logic [REG_IDX_W-1:0]   id_rs1,
    input  logic [REG_IDX_W-1:0]   id_rs2,
    input  logic                   ex_mem_read,
    input  logic [REG_IDX_W-1:0]   ex_rd,
    input  logic                   ex_branch_taken,
    input  logic [XLEN-1:0]        ex_branch_target,
    input  logic                   mem_busy,
    output logic [XLEN-1:0]        pc_next,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   pipe_hold,
    output logic                   misalign_err,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [1:0]             seq_state
);

    seq_state_t       state;
    seq_state_t       state_nx;
    logic             pending_valid;
    logic             pending_valid_nx;
    logic [XLEN-1:0]  pending_target;
    logic [XLEN-1:0]  pending_target_nx;
    logic             load_use;
    logic             redirect;
    logic [XLEN-1:0]  redirect_target;

    hazard_detect u_hazard_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .load_use    (load_use)
    );

    always_comb begin
        pc_next           = pc_current + XLEN'(PC_STEP);
        pc_write          = 1'b0;
        if_id_write       = 1'b0;
        if_id_flush       = 1'b0;
        id_ex_flush       = 1'b0;
        pipe_hold         = 1'b0;
        redirect          = 1'b0;
        redirect_target   = ex_branch_target;
        state_nx          = state;
        pending_valid_nx  = pending_valid;
        pending_target_nx = pending_target;

        if (reset) begin
            pc_next     = RESET_VECTOR;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (state)
                BOOT: begin
                    pc_next     = RESET_VECTOR;
                    pc_write    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_nx    = RUN;
                end
                RUN, MEM_WAIT: begin
                    if (mem_busy) begin
                        pipe_hold = 1'b1;
                        state_nx  = MEM_WAIT;
                        // The frozen EX branch re-asserts every cycle; keep the first target
                        if (ex_branch_taken && !pending_valid) begin
                            pending_valid_nx  = 1'b1;
                            pending_target_nx = ex_branch_target;
                        end
                    end else begin
                        state_nx         = RUN;
                        pending_valid_nx = 1'b0;
                        if (pending_valid) begin
                            redirect        = 1'b1;
                            redirect_target = pending_target;
                        end else if (ex_branch_taken) begin
                            redirect = 1'b1;
                        end else if (load_use) begin
                            id_ex_flush = 1'b1;
                        end else begin
                            pc_write    = 1'b1;
                            if_id_write = 1'b1;
                        end

                        if (redirect) begin
                            pc_next     = redirect_target;
                            pc_write    = 1'b1;
                            if_id_flush = 1'b1;
                            id_ex_flush = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nx = BOOT;
                end
            endcase
        end

        misalign_err = redirect && (redirect_target[1:0] != 2'b00);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= BOOT;
            pending_valid  <= 1'b0;
            pending_target <= '0;
            stall_cycles   <= '0;
        end else begin
            state          <= state_nx;
            pending_valid  <= pending_valid_nx;
            pending_target <= pending_target_nx;
            if (!pc_write && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + STALL_CNT_W'(1);
            end
        end
    end

    assign seq_state = state;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
//==============================================================================
// Module   : tb_pc_sequencer
// Brief    : Randomized self-checking bench for pc_sequencer against a rule model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pc_sequencer;

    localparam logic [63:0] RV = 64'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc_current;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_mem_read, ex_branch_taken, mem_busy;
    logic [63:0] ex_branch_target;

    logic [63:0] pc_next, pc_next_s;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, misalign_err;
    logic        pc_write_s, if_id_write_s, if_id_flush_s, id_ex_flush_s, pipe_hold_s, misalign_err_s;
    logic [31:0] stall_cycles;
    logic [3:0]  stall_cycles_s;
    logic [1:0]  seq_state, seq_state_s;

    pc_sequencer #(.XLEN(64), .RESET_VECTOR(RV), .STALL_CNT_W(32)) dut (
        .clk(clk), .reset(reset), .pc_current(pc_current),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .mem_busy(mem_busy), .pc_next(pc_next), .pc_write(pc_write),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .pipe_hold(pipe_hold), .misalign_err(misalign_err),
        .stall_cycles(stall_cycles), .seq_state(seq_state)
    );

    pc_sequencer #(.XLEN(64), .RESET_VECTOR(RV), .STALL_CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .pc_current(pc_current),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .mem_busy(mem_busy), .pc_next(pc_next_s), .pc_write(pc_write_s),
        .if_id_write(if_id_write_s), .if_id_flush(if_id_flush_s), .id_ex_flush(id_ex_flush_s),
        .pipe_hold(pipe_hold_s), .misalign_err(misalign_err_s),
        .stall_cycles(stall_cycles_s), .seq_state(seq_state_s)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: 0 = booting, 1 = running, 2 = waiting on memory
    int              m_mode  = 0;
    bit              m_pend  = 1'b0;
    logic [63:0]     m_tgt   = '0;
    longint unsigned m_st32  = 0;
    longint unsigned m_st4   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        ex_mem_read      = 1'b0;
        ex_rd            = 5'd0;
        id_rs1           = 5'd0;
        id_rs2           = 5'd0;
        ex_branch_taken  = 1'b0;
        ex_branch_target = 64'h0;
        mem_busy         = 1'b0;
    endtask

    // Inputs are applied just after a falling edge; outputs are checked 1 unit later.
    task automatic step();
        logic [63:0] e_pc;
        bit e_pw, e_iw, e_iff, e_idf, e_hold, e_mis, pc_chk, lu, busy_freeze;
        #1;
        if (reset) begin
            m_mode = 0; m_pend = 1'b0; m_tgt = '0; m_st32 = 0; m_st4 = 0;
        end
        e_pw = 0; e_iw = 0; e_iff = 0; e_idf = 0; e_hold = 0; e_mis = 0; pc_chk = 1;
        busy_freeze = 0;
        e_pc = pc_current + 64'd4;
        lu = ex_mem_read && (ex_rd != 0) && (ex_rd == id_rs1 || ex_rd == id_rs2);

        if (reset) begin
            e_pc = RV; e_iff = 1; e_idf = 1;
        end else if (m_mode == 0) begin
            e_pc = RV; e_pw = 1; e_iff = 1; e_idf = 1;
        end else if (mem_busy) begin
            e_hold = 1; pc_chk = 0; busy_freeze = 1;
        end else if ((m_mode == 2 && m_pend) || ex_branch_taken) begin
            e_pc  = (m_mode == 2 && m_pend) ? m_tgt : ex_branch_target;
            e_pw  = 1; e_iff = 1; e_idf = 1;
            e_mis = (e_pc % 4) != 0;
        end else if (lu) begin
            e_idf = 1; pc_chk = 0;
        end else begin
            e_pw = 1; e_iw = 1;
        end

        check("pc_write",     64'(pc_write),     64'(e_pw));
        check("if_id_write",  64'(if_id_write),  64'(e_iw));
        check("if_id_flush",  64'(if_id_flush),  64'(e_iff));
        check("id_ex_flush",  64'(id_ex_flush),  64'(e_idf));
        check("pipe_hold",    64'(pipe_hold),    64'(e_hold));
        check("misalign_err", 64'(misalign_err), 64'(e_mis));
        check("seq_state",    64'(seq_state),    64'(m_mode));
        check("stall_cycles", 64'(stall_cycles), m_st32);
        if (pc_chk) check("pc_next", pc_next, e_pc);
        check("s_pc_write",     64'(pc_write_s),     64'(e_pw));
        check("s_if_id_write",  64'(if_id_write_s),  64'(e_iw));
        check("s_flushes",      64'({if_id_flush_s, id_ex_flush_s}), 64'({e_iff, e_idf}));
        check("s_hold_mis",     64'({pipe_hold_s, misalign_err_s}),  64'({e_hold, e_mis}));
        check("s_seq_state",    64'(seq_state_s),    64'(m_mode));
        check("s_stall_cycles", 64'(stall_cycles_s), m_st4);
        if (pc_chk) check("s_pc_next", pc_next_s, e_pc);

        if (!reset) begin
            if (!e_pw) begin
                if (m_st32 < 64'hFFFF_FFFF) m_st32++;
                if (m_st4 < 15) m_st4++;
            end
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (busy_freeze) begin
                if (ex_branch_taken && !m_pend) begin
                    m_pend = 1'b1;
                    m_tgt  = ex_branch_target;
                end
                m_mode = 2;
            end else begin
                m_pend = 1'b0;
                m_mode = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset      = 1'b1;
        pc_current = 64'h40;
        @(negedge clk);

        // Reset then boot, then sequential fetch
        repeat (3) step();
        reset = 1'b0;
        step();
        step();

        // Load-use stall, then a load to x0 which must not stall
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
        step();
        ex_rd = 5'd0; id_rs2 = 5'd0;
        step();
        idle(); step();

        // Branch beats a simultaneous load-use
        ex_branch_taken = 1'b1; ex_branch_target = 64'h1000;
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
        step();
        idle(); step();

        // Branch held through a memory wait; later target change is ignored
        mem_busy = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 64'h2000;
        step(); step();
        ex_branch_target = 64'h3000;
        step(); step();
        mem_busy = 1'b0;
        step();
        idle(); step();

        // PC wrap and misaligned redirect
        pc_current = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        ex_branch_taken = 1'b1; ex_branch_target = 64'h1002;
        step();
        idle(); step();

        // Reset during a memory wait discards the pending target
        mem_busy = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 64'h5000;
        step(); step();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        idle();
        step(); step();

        // Long freeze saturates the narrow counter
        mem_busy = 1'b1;
        repeat (20) step();
        mem_busy = 1'b0;
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(0, 199) == 0);
            mem_busy        = ($urandom_range(0, 3) == 0);
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            ex_branch_target = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) ex_branch_target[1:0] = 2'b00;
            ex_mem_read = ($urandom_range(0, 9) < 4);
            ex_rd       = 5'($urandom_range(0, 3));
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            pc_current  = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                                       : {$urandom, $urandom & 32'hFFFF_FFFC};
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
